// File: rtl/c499_key_pkg.sv
// c499_key_pkg
// Shared constants and FSM state type for the c499 key loader.
//   KEY_W    : width of the applied key (p4..p1 plus X_18..X_1)
//   CRC_W    : width of the CRC protecting the key
//   CRC_POLY : CRC-8 polynomial x^8+x^2+x+1
//   CNT_W    : width of the bit counter used for both key and CRC phases
package c499_key_pkg;

  localparam int unsigned KEY_W = 22;
  localparam int unsigned CRC_W = 8;
  localparam int unsigned CNT_W = 5;

  localparam logic [CRC_W-1:0] CRC_POLY = 8'h07;

  // Counter values of the final bit in each phase.
  localparam logic [CNT_W-1:0] KEY_LAST = 5'd21;
  localparam logic [CNT_W-1:0] CRC_LAST = 5'd7;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_KEY = 2'd1,
    SHIFT_CRC = 2'd2,
    CHECK     = 2'd3
  } state_t;

endpackage

// File: rtl/crc8_serial.sv
// crc8_serial
// Bit-serial CRC-8 (poly CRC_POLY, init 0) over the incoming key bits.
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset, clears crc
//   clr : synchronous clear back to the initial value (wins over en)
//   en  : advance the CRC by one bit using din
//   din : serial data bit
//   crc : current CRC value
module crc8_serial
  import c499_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [CRC_W-1:0] crc
);

  logic w_fb;

  assign w_fb = crc[CRC_W-1] ^ din;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : {CRC_W{1'b0}});
    end
  end

endmodule

// File: rtl/c499_key_loader.sv
// c499_key_loader
// Receives a 22-bit key serially (LSB first) followed by its CRC-8 (MSB
// first), verifies the CRC and only then applies the key. A previously
// applied key remains on key_out throughout a reload.
// Ports:
//   clk           : clock, rising edge
//   rst           : asynchronous active-high reset
//   key_start     : pulse, begins or restarts a load from any state
//   key_sin       : serial key/CRC data bit
//   key_sin_valid : key_sin is sampled only while this is high
//   key_out       : applied key, {X_18..X_1, p4..p1}
//   key_valid     : key_out holds a CRC-verified key
//   busy          : loader is not in IDLE
//   err           : last load failed its CRC check (held until key_start)
module c499_key_loader
  import c499_key_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             key_start,
  input  logic             key_sin,
  input  logic             key_sin_valid,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [KEY_W-1:0]   r_shift;
  logic [CRC_W-1:0]   r_rx_crc;
  logic [CRC_W-1:0]   w_crc;
  logic               w_key_bit;
  logic               w_crc_bit;
  logic               w_phase_end;
  logic               w_check_exit;
  logic               w_match;

  // ---- Next-state decode ----
  always_comb begin
    w_state_nxt = r_state;
    w_key_bit   = 1'b0;
    w_crc_bit   = 1'b0;
    w_phase_end = 1'b0;
    if (key_start) begin
      // Restart wins over everything; a bit sampled in this cycle is dropped.
      w_state_nxt = SHIFT_KEY;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        SHIFT_KEY: begin
          if (key_sin_valid) begin
            w_key_bit = 1'b1;
            if (r_cnt == KEY_LAST) begin
              w_phase_end = 1'b1;
              w_state_nxt = SHIFT_CRC;
            end
          end
        end
        SHIFT_CRC: begin
          if (key_sin_valid) begin
            w_crc_bit = 1'b1;
            if (r_cnt == CRC_LAST) begin
              w_phase_end = 1'b1;
              w_state_nxt = CHECK;
            end
          end
        end
        CHECK: begin
          w_state_nxt = IDLE;
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign w_check_exit = (r_state == CHECK) && !key_start;
  assign w_match      = (w_crc == r_rx_crc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---- Shift / count stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_rx_crc <= '0;
    end else begin
      if (key_start || w_phase_end) begin
        r_cnt <= '0;
      end else if (w_key_bit || w_crc_bit) begin
        r_cnt <= r_cnt + 5'd1;
      end
      // Shifting right so the first key bit ends up in bit 0.
      if (w_key_bit) begin
        r_shift <= {key_sin, r_shift[KEY_W-1:1]};
      end
      // Received CRC arrives MSB first.
      if (w_crc_bit) begin
        r_rx_crc <= {r_rx_crc[CRC_W-2:0], key_sin};
      end
    end
  end

  crc8_serial u_crc (
    .clk (clk),
    .rst (rst),
    .clr (key_start),
    .en  (w_key_bit),
    .din (key_sin),
    .crc (w_crc)
  );

  // ---- Output stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_out   <= '0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else if (key_start) begin
      // key_out is deliberately kept so the old key stays applied.
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else if (w_check_exit) begin
      if (w_match) begin
        key_out   <= r_shift;
        key_valid <= 1'b1;
        err       <= 1'b0;
      end else begin
        key_out   <= '0;
        key_valid <= 1'b0;
        err       <= 1'b1;
      end
    end
  end

  assign busy = (r_state != IDLE);

endmodule

// File: tb/tb_c499_key_loader.sv
module tb_c499_key_loader;

  logic        clk;
  logic        rst;
  logic        key_start;
  logic        key_sin;
  logic        key_sin_valid;
  logic [21:0] key_out;
  logic        key_valid;
  logic        busy;
  logic        err;

  int checks;
  int failures;

  c499_key_loader dut (
    .clk           (clk),
    .rst           (rst),
    .key_start     (key_start),
    .key_sin       (key_sin),
    .key_sin_valid (key_sin_valid),
    .key_out       (key_out),
    .key_valid     (key_valid),
    .busy          (busy),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [21:0] key;
    logic [7:0]  crc;
    bit          gaps;
    bit          exp_ok;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [7:0] crc_model(input logic [21:0] k);
    logic [7:0] c;
    logic       fb;
    c = 8'h00;
    for (int i = 0; i < 22; i++) begin
      fb = c[7] ^ k[i];
      c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cycle(input logic s, input logic d, input logic v);
    @(negedge clk);
    key_start     = s;
    key_sin       = d;
    key_sin_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input bit en);
    if (en) begin
      repeat ($urandom_range(0, 2)) cycle(1'b0, ^$urandom, 1'b0);
    end
  endtask

  // Full load: start pulse, 22 key bits LSB first, 8 CRC bits MSB first,
  // then the CHECK cycle. Returns one edge after CHECK exit.
  task automatic load(input logic [21:0] key, input logic [7:0] crc, input bit gaps,
                      input bit start_vld, input bit chk_hold, input logic [21:0] hold);
    cycle(1'b1, start_vld, start_vld);
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_kvalid", {31'd0, key_valid}, 32'd0);
    chk("start_err", {31'd0, err}, 32'd0);
    for (int i = 0; i < 22; i++) begin
      gap(gaps);
      cycle(1'b0, key[i], 1'b1);
      if (chk_hold) begin
        chk("hold_key_out", {10'd0, key_out}, {10'd0, hold});
        chk("hold_kvalid", {31'd0, key_valid}, 32'd0);
      end
    end
    for (int i = 7; i >= 0; i--) begin
      gap(gaps);
      cycle(1'b0, crc[i], 1'b1);
      if (chk_hold) begin
        chk("hold_key_out", {10'd0, key_out}, {10'd0, hold});
        chk("hold_kvalid", {31'd0, key_valid}, 32'd0);
      end
    end
    // One edge after the last CRC bit: in CHECK, nothing published yet.
    chk("check_busy", {31'd0, busy}, 32'd1);
    chk("check_kvalid", {31'd0, key_valid}, 32'd0);
    chk("check_err", {31'd0, err}, 32'd0);
    cycle(1'b0, ^$urandom, 1'b1);
  endtask

  task automatic expect_result(input string tag, input bit ok, input logic [21:0] key);
    chk({tag, "_kvalid"}, {31'd0, key_valid}, {31'd0, ok});
    chk({tag, "_err"}, {31'd0, err}, {31'd0, !ok});
    chk({tag, "_key_out"}, {10'd0, key_out}, ok ? {10'd0, key} : 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [21:0] k;
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    key_start     = 1'b0;
    key_sin       = 1'b0;
    key_sin_valid = 1'b0;

    tbl[0] = '{key: 22'h000000, crc: 8'h00,                     gaps: 1'b0, exp_ok: 1'b1};
    tbl[1] = '{key: 22'h000000, crc: 8'h01,                     gaps: 1'b0, exp_ok: 1'b0};
    tbl[2] = '{key: 22'h2AAAAA, crc: crc_model(22'h2AAAAA),        gaps: 1'b1, exp_ok: 1'b1};
    tbl[3] = '{key: 22'h3FFFFF, crc: crc_model(22'h3FFFFF),        gaps: 1'b0, exp_ok: 1'b1};
    tbl[4] = '{key: 22'h155555, crc: crc_model(22'h155555) ^ 8'h80, gaps: 1'b1, exp_ok: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_key_out", {10'd0, key_out}, 32'd0);
    chk("rst_kvalid", {31'd0, key_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Valid bits in IDLE are ignored.
    repeat (3) cycle(1'b0, 1'b1, 1'b1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    for (int v = 0; v < 5; v++) begin
      load(tbl[v].key, tbl[v].crc, tbl[v].gaps, 1'b0, 1'b0, 22'd0);
      expect_result($sformatf("vec%0d", v), tbl[v].exp_ok, tbl[v].key);
      repeat (2) cycle(1'b0, ^$urandom, 1'b1);
      expect_result($sformatf("vec%0d_hold", v), tbl[v].exp_ok, tbl[v].key);
    end

    // Good key applied, then a reload: old key stays until the new CHECK exit.
    load(22'h3FFFFF, crc_model(22'h3FFFFF), 1'b0, 1'b0, 1'b0, 22'd0);
    expect_result("good_ff", 1'b1, 22'h3FFFFF);
    load(22'h0ABCDE, crc_model(22'h0ABCDE), 1'b1, 1'b0, 1'b1, 22'h3FFFFF);
    expect_result("reload", 1'b1, 22'h0ABCDE);

    // Restart at key bit 10, with a valid bit in the restart cycle.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b1);
    k = 22'h1C3A5F;
    load(k, crc_model(k), 1'b0, 1'b1, 1'b1, 22'h0ABCDE);
    expect_result("restart", 1'b1, k);

    // Async reset during CRC bit 3.
    cycle(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) cycle(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_key_out", {10'd0, key_out}, 32'd0);
    chk("async_rst_kvalid", {31'd0, key_valid}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Partial load discarded: remaining bits without key_start do nothing.
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
    end
    chk("post_rst_kvalid", {31'd0, key_valid}, 32'd0);
    chk("post_rst_err", {31'd0, err}, 32'd0);

    k = 22'h2F0F0F;
    load(k, crc_model(k), 1'b0, 1'b0, 1'b0, 22'd0);
    expect_result("after_rst", 1'b1, k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
